// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for the async SRAM wrapper.
// Define SRAM_ARB_FIXED_PRIO_EN to give port B absolute priority on contention.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iA_REQ,
    input  logic        iA_WE,
    input  logic [17:0] iA_ADDR,
    input  logic [1:0]  iA_BE_N,
    input  logic [15:0] iA_WDATA,
    output logic        oA_ACK,
    output logic [15:0] oA_RDATA,
    input  logic        iB_REQ,
    input  logic        iB_WE,
    input  logic [17:0] iB_ADDR,
    input  logic [1:0]  iB_BE_N,
    input  logic [15:0] iB_WDATA,
    output logic        oB_ACK,
    output logic [15:0] oB_RDATA,
    output logic [17:0] oSRAM_ADDR,
    output logic [1:0]  oSRAM_BE_N,
    output logic        oSRAM_CE_N,
    output logic        oSRAM_OE_N,
    output logic        oSRAM_WE_N,
    output logic [15:0] oSRAM_WDATA,
    input  logic [15:0] iSRAM_RDATA
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_b_q, gnt_b_d;
    logic        we_q, we_d;
    logic        pick_b;
    logic [17:0] addr_d;
    logic [1:0]  be_d;
    logic        ce_d, oe_d, wen_d;
    logic [15:0] wdata_d;
    logic        a_ack_d, b_ack_d;
    logic [15:0] a_rdata_d, b_rdata_d;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    assign pick_b = iB_REQ;
`else
    logic last_b_q, last_b_d;
    // On contention, the port that was not granted last wins.
    assign pick_b = iB_REQ && (!iA_REQ || !last_b_q);
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_b_d   = gnt_b_q;
        we_d      = we_q;
        addr_d    = oSRAM_ADDR;
        be_d      = oSRAM_BE_N;
        ce_d      = oSRAM_CE_N;
        oe_d      = oSRAM_OE_N;
        wen_d     = oSRAM_WE_N;
        wdata_d   = oSRAM_WDATA;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = oA_RDATA;
        b_rdata_d = oB_RDATA;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_b_d  = last_b_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (iA_REQ || iB_REQ) begin
                    gnt_b_d = pick_b;
                    we_d    = pick_b ? iB_WE    : iA_WE;
                    addr_d  = pick_b ? iB_ADDR  : iA_ADDR;
                    be_d    = pick_b ? iB_BE_N  : iA_BE_N;
                    wdata_d = pick_b ? iB_WDATA : iA_WDATA;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    ce_d    = 1'b0;
                    oe_d    = we_d;
                    wen_d   = !we_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_b_d = pick_b;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q && gnt_b_q)  b_rdata_d = iSRAM_RDATA;
                    if (!we_q && !gnt_b_q) a_rdata_d = iSRAM_RDATA;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    wen_d   = 1'b1;
                    a_ack_d = !gnt_b_q;
                    b_ack_d = gnt_b_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_b_q     <= 1'b0;
            we_q        <= 1'b0;
            oSRAM_ADDR  <= '0;
            oSRAM_BE_N  <= 2'b11;
            oSRAM_CE_N  <= 1'b1;
            oSRAM_OE_N  <= 1'b1;
            oSRAM_WE_N  <= 1'b1;
            oSRAM_WDATA <= '0;
            oA_ACK      <= 1'b0;
            oB_ACK      <= 1'b0;
            oA_RDATA    <= '0;
            oB_RDATA    <= '0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q    <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_b_q     <= gnt_b_d;
            we_q        <= we_d;
            oSRAM_ADDR  <= addr_d;
            oSRAM_BE_N  <= be_d;
            oSRAM_CE_N  <= ce_d;
            oSRAM_OE_N  <= oe_d;
            oSRAM_WE_N  <= wen_d;
            oSRAM_WDATA <= wdata_d;
            oA_ACK      <= a_ack_d;
            oB_ACK      <= b_ack_d;
            oA_RDATA    <= a_rdata_d;
            oB_RDATA    <= b_rdata_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_b_q    <= last_b_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM model.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [17:0] a_addr, b_addr;
    logic [1:0]  a_be, b_be;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [17:0] sram_addr;
    logic [1:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0] sram_wdata, sram_rdata;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:262143];

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .iCLK(clk), .iRST(rst),
        .iA_REQ(a_req), .iA_WE(a_we), .iA_ADDR(a_addr),
        .iA_BE_N(a_be), .iA_WDATA(a_wdata),
        .oA_ACK(a_ack), .oA_RDATA(a_rdata),
        .iB_REQ(b_req), .iB_WE(b_we), .iB_ADDR(b_addr),
        .iB_BE_N(b_be), .iB_WDATA(b_wdata),
        .oB_ACK(b_ack), .oB_RDATA(b_rdata),
        .oSRAM_ADDR(sram_addr), .oSRAM_BE_N(sram_be_n),
        .oSRAM_CE_N(sram_ce_n), .oSRAM_OE_N(sram_oe_n),
        .oSRAM_WE_N(sram_we_n), .oSRAM_WDATA(sram_wdata),
        .iSRAM_RDATA(sram_rdata)
    );

    // SRAM model: byte-masked write while CE/WE low, async read while CE/OE low
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_be_n[0]) mem[sram_addr][7:0]  <= sram_wdata[7:0];
            if (!sram_be_n[1]) mem[sram_addr][15:8] <= sram_wdata[15:8];
        end
    end
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    task automatic run_access(input bit pb, input bit we,
                              input logic [17:0] addr, input logic [1:0] be,
                              input logic [15:0] wd,
                              output int ack_cyc, output int we_lo,
                              output int oe_lo, output int bad,
                              output logic [15:0] rd);
        ack_cyc = -1; we_lo = 0; oe_lo = 0; bad = 0; rd = '0;
        @(posedge clk); #1;
        if (pb) begin
            b_req = 1; b_we = we; b_addr = addr; b_be = be; b_wdata = wd;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
        end
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!sram_we_n) we_lo++;
            if (!sram_oe_n) oe_lo++;
            if (sram_addr !== addr || sram_be_n !== be) bad++;
            if (we && sram_wdata !== wd) bad++;
            if (pb ? b_ack : a_ack) begin
                ack_cyc = c;
                rd = pb ? b_rdata : a_rdata;
                break;
            end
        end
        a_req = 0;
        b_req = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 111", {sram_ce_n, sram_oe_n, sram_we_n});
        end
        checks++;
        if (sram_be_n !== 2'b11) begin
            errors++;
            $display("FAIL reset_be: got %b want 11", sram_be_n);
        end
        checks++;
        if ({a_ack, b_ack} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ack: got %b want 00", {a_ack, b_ack});
        end
        checks++;
        if (a_rdata !== 16'h0 || b_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h want 0000/0000", a_rdata, b_rdata);
        end
        checks++;
        if (sram_addr !== 18'h0 || sram_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_addr: got %h/%h want 0/0", sram_addr, sram_wdata);
        end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_write_read();
        int ac, wl, ol, bd;
        logic [15:0] rd;
        run_access(0, 1, 18'h00010, 2'b00, 16'h1234, ac, wl, ol, bd, rd);
        checks++;
        if (ac !== 3) begin
            errors++;
            $display("FAIL wr_ack_cycle: got %0d want 3", ac);
        end
        checks++;
        if (wl !== 2 || ol !== 0) begin
            errors++;
            $display("FAIL wr_strobes: we_lo %0d oe_lo %0d want 2 0", wl, ol);
        end
        checks++;
        if (bd !== 0) begin
            errors++;
            $display("FAIL wr_bus_stable: got %0d bad cycles want 0", bd);
        end
        checks++;
        if (rd !== 16'h0) begin
            errors++;
            $display("FAIL wr_rdata_kept: got %h want 0000", rd);
        end
        checks++;
        if (mem[18'h00010] !== 16'h1234) begin
            errors++;
            $display("FAIL wr_mem: got %h want 1234", mem[18'h00010]);
        end
        run_access(0, 0, 18'h00010, 2'b00, 16'h0, ac, wl, ol, bd, rd);
        checks++;
        if (ac !== 3 || wl !== 0 || ol !== 2) begin
            errors++;
            $display("FAIL rd_timing: ack %0d we_lo %0d oe_lo %0d want 3 0 2", ac, wl, ol);
        end
        checks++;
        if (rd !== 16'h1234) begin
            errors++;
            $display("FAIL rd_data: got %h want 1234", rd);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0 || a_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL rd_hold: ack %b rdata %h want 0 1234", a_ack, a_rdata);
        end
    endtask

    task automatic test_contention();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        localparam int NACK = 5;
        bit exp_b [5] = '{1, 1, 1, 1, 0};
`else
        localparam int NACK = 6;
        bit exp_b [6] = '{0, 1, 0, 1, 0, 1};
`endif
        bit got_b [6];
        int cyc [6];
        int n = 0;
        int dual = 0;
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        a_we = 0; a_addr = 18'h10; a_be = 2'b00;
        b_we = 0; b_addr = 18'h10; b_be = 2'b00;
        a_req = 1; b_req = 1;
        @(posedge clk);
        for (int c = 1; c <= 40 && n < NACK; c++) begin
            @(negedge clk);
            if (a_ack && b_ack) dual++;
            if (a_ack || b_ack) begin
                got_b[n] = b_ack;
                cyc[n] = c;
                n++;
`ifdef SRAM_ARB_FIXED_PRIO_EN
                if (n == 4) b_req = 0;
`endif
                if (n == NACK) begin
                    a_req = 0;
                    b_req = 0;
                end
            end
        end
        a_req = 0;
        b_req = 0;
        checks++;
        if (n !== NACK) begin
            errors++;
            $display("FAIL cont_count: got %0d acks want %0d", n, NACK);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL cont_order[%0d]: got port_b=%b want %b", i, got_b[i], exp_b[i]);
            end
            if (i > 0) begin
                checks++;
                if (cyc[i] - cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL cont_gap[%0d]: got %0d want 4", i, cyc[i] - cyc[i-1]);
                end
            end
        end
        checks++;
        if (dual !== 0) begin
            errors++;
            $display("FAIL cont_dual_ack: got %0d want 0", dual);
        end
    endtask

    task automatic test_byte_write();
        int ac, wl, ol, bd;
        logic [15:0] rd;
        @(posedge clk);
        mem[18'h3FFFF] <= 16'h5A5A;
        @(posedge clk);
        run_access(1, 1, 18'h3FFFF, 2'b10, 16'hABCD, ac, wl, ol, bd, rd);
        checks++;
        if (ac !== 3 || wl !== 2 || bd !== 0) begin
            errors++;
            $display("FAIL bw_access: ack %0d we_lo %0d bad %0d want 3 2 0", ac, wl, bd);
        end
        checks++;
        if (mem[18'h3FFFF] !== 16'h5ACD) begin
            errors++;
            $display("FAIL bw_mem: got %h want 5acd", mem[18'h3FFFF]);
        end
        run_access(1, 0, 18'h3FFFF, 2'b00, 16'h0, ac, wl, ol, bd, rd);
        checks++;
        if (ac !== 3 || rd !== 16'h5ACD) begin
            errors++;
            $display("FAIL bw_readback: ack %0d data %h want 3 5acd", ac, rd);
        end
    endtask

    task automatic test_reset_mid();
        int ac, wl, ol, bd;
        int late_ack = 0;
        logic [15:0] rd;
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_addr = 18'h200; a_be = 2'b00; a_wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sram_ce_n !== 1'b0 || sram_we_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_started: ce %b we %b want 0 0", sram_ce_n, sram_we_n);
        end
        rst = 1;
        a_req = 0;
        @(negedge clk);
        checks++;
        if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111 || a_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: strobes %b ack %b want 111 0",
                     {sram_ce_n, sram_oe_n, sram_we_n}, a_ack);
        end
        @(posedge clk); #1;
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_ack || b_ack) late_ack++;
        end
        checks++;
        if (late_ack !== 0) begin
            errors++;
            $display("FAIL mid_no_ack: got %0d acks want 0", late_ack);
        end
        run_access(0, 0, 18'h00010, 2'b00, 16'h0, ac, wl, ol, bd, rd);
        checks++;
        if (ac !== 3 || rd !== 16'h1234) begin
            errors++;
            $display("FAIL mid_recover: ack %0d data %h want 3 1234", ac, rd);
        end
    endtask

    initial begin
        rst = 1;
        a_req = 0; a_we = 0; a_addr = '0; a_be = 2'b11; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_be = 2'b11; b_wdata = '0;
        test_reset();
        test_write_read();
        test_contention();
        test_byte_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
